// File: rtl/xilinx_drp_arbiter.sv
// Round-robin arbiter sharing one transceiver DRP port among NUM_LANES lane PHYs.
// One outstanding transaction at a time, with a timeout abort when drdy never returns.
module xilinx_drp_arbiter #(
    parameter int NUM_LANES      = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    dclk_i,
    input  logic                    reset_n_i,
    input  logic [NUM_LANES-1:0]    req_i,
    output logic [NUM_LANES-1:0]    gnt_o,
    input  logic [NUM_LANES-1:0]    lane_den_i,
    input  logic [NUM_LANES-1:0]    lane_dwe_i,
    input  logic [16*NUM_LANES-1:0] lane_daddr_i,
    input  logic [16*NUM_LANES-1:0] lane_di_i,
    output logic [NUM_LANES-1:0]    lane_drdy_o,
    output logic [15:0]             lane_drpdo_o,
    output logic                    drp_den_o,
    output logic                    drp_dwe_o,
    output logic [15:0]             drp_daddr_o,
    output logic [15:0]             drp_di_o,
    input  logic                    drp_drdy_i,
    input  logic [15:0]             drp_drpdo_i,
    output logic                    timeout_o
);
    localparam int OW = $clog2(NUM_LANES);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;

    state_t                     state, state_nxt;
    logic [OW-1:0]              owner, owner_nxt, last_owner, last_owner_nxt;
    logic [OW-1:0]              sel, cand;
    logic                       sel_vld;
    logic [CW-1:0]              cnt, cnt_nxt;
    logic [NUM_LANES-1:0]       gnt_nxt, lane_drdy_nxt;
    logic [15:0]                lane_drpdo_nxt, drp_daddr_nxt, drp_di_nxt;
    logic                       drp_den_nxt, drp_dwe_nxt, timeout_nxt;
    logic [NUM_LANES-1:0][15:0] daddr_a, di_a;

    assign daddr_a = lane_daddr_i;
    assign di_a    = lane_di_i;

    // Scan farthest-to-nearest so the first requester after last_owner wins.
    always_comb begin
        sel     = last_owner;
        sel_vld = 1'b0;
        cand    = '0;
        for (int i = NUM_LANES; i >= 1; i--) begin
            cand = OW'((int'(last_owner) + i) % NUM_LANES);
            if (req_i[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        gnt_nxt        = gnt_o;
        lane_drdy_nxt  = '0;
        lane_drpdo_nxt = lane_drpdo_o;
        drp_den_nxt    = 1'b0;
        drp_dwe_nxt    = drp_dwe_o;
        drp_daddr_nxt  = drp_daddr_o;
        drp_di_nxt     = drp_di_o;
        timeout_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    owner_nxt      = sel;
                    last_owner_nxt = sel;
                    gnt_nxt        = '0;
                    gnt_nxt[sel]   = 1'b1;
                    state_nxt      = GRANT;
                end
            end
            GRANT: begin
                // den wins over a simultaneous request release
                if (lane_den_i[owner]) begin
                    drp_den_nxt   = 1'b1;
                    drp_dwe_nxt   = lane_dwe_i[owner];
                    drp_daddr_nxt = daddr_a[owner];
                    drp_di_nxt    = di_a[owner];
                    cnt_nxt       = '0;
                    state_nxt     = WAIT;
                end else if (!req_i[owner]) begin
                    gnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (drp_drdy_i || cnt == TERM) begin
                    lane_drdy_nxt[owner] = 1'b1;
                    lane_drpdo_nxt       = drp_drdy_i ? drp_drpdo_i : 16'hFFFF;
                    timeout_nxt          = !drp_drdy_i;
                    if (req_i[owner]) begin
                        state_nxt = GRANT;
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge dclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            owner        <= '0;
            last_owner   <= OW'(NUM_LANES - 1);
            cnt          <= '0;
            gnt_o        <= '0;
            lane_drdy_o  <= '0;
            lane_drpdo_o <= '0;
            drp_den_o    <= 1'b0;
            drp_dwe_o    <= 1'b0;
            drp_daddr_o  <= '0;
            drp_di_o     <= '0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            last_owner   <= last_owner_nxt;
            cnt          <= cnt_nxt;
            gnt_o        <= gnt_nxt;
            lane_drdy_o  <= lane_drdy_nxt;
            lane_drpdo_o <= lane_drpdo_nxt;
            drp_den_o    <= drp_den_nxt;
            drp_dwe_o    <= drp_dwe_nxt;
            drp_daddr_o  <= drp_daddr_nxt;
            drp_di_o     <= drp_di_nxt;
            timeout_o    <= timeout_nxt;
        end
    end
endmodule

// File: tb/tb_xilinx_drp_arbiter.sv
// Bench for xilinx_drp_arbiter: directed scenarios, then random lane/DRP-slave
// traffic, all checked every cycle against a cycle-level reference model.
module tb_xilinx_drp_arbiter;
    localparam int NL = 4;
    localparam int TO = 8;

    logic          clk, rst_n;
    logic [NL-1:0] req, den, dwe;
    logic [63:0]   daddr, di;
    logic          drdy;
    logic [15:0]   drpdo;
    logic [NL-1:0] gnt_o, lane_drdy_o;
    logic [15:0]   lane_drpdo_o, drp_daddr_o, drp_di_o;
    logic          drp_den_o, drp_dwe_o, timeout_o;

    int n_asrt = 0;
    int n_fail = 0;

    // reference model state
    logic [NL-1:0] m_gnt, m_ldrdy;
    int            m_own, m_last, m_age;
    bit            m_busy, m_den, m_to, m_dwe;
    logic [15:0]   m_addr, m_di, m_do;

    // random-phase agent state
    bit            started [NL];
    bit            inwait  [NL];
    bit            sl_busy;
    int            sl_d, sl_k;

    xilinx_drp_arbiter #(.NUM_LANES(NL), .TIMEOUT_CYCLES(TO)) dut (
        .dclk_i(clk), .reset_n_i(rst_n), .req_i(req), .gnt_o(gnt_o),
        .lane_den_i(den), .lane_dwe_i(dwe), .lane_daddr_i(daddr), .lane_di_i(di),
        .lane_drdy_o(lane_drdy_o), .lane_drpdo_o(lane_drpdo_o),
        .drp_den_o(drp_den_o), .drp_dwe_o(drp_dwe_o), .drp_daddr_o(drp_daddr_o),
        .drp_di_o(drp_di_o), .drp_drdy_i(drdy), .drp_drpdo_i(drpdo), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        req = '0; den = '0; dwe = '0; daddr = '0; di = '0; drdy = 1'b0; drpdo = '0;
    endtask

    task automatic model_reset();
        m_gnt = '0; m_ldrdy = '0; m_own = 0; m_last = NL - 1; m_age = 0;
        m_busy = 0; m_den = 0; m_to = 0; m_dwe = 0; m_addr = '0; m_di = '0; m_do = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({gnt_o, lane_drdy_o, lane_drpdo_o, drp_den_o, drp_dwe_o,
                      drp_daddr_o, drp_di_o, timeout_o}), 64'h0);
    endtask

    // Called between edges; asynchronous reset must take effect without a clock.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset_hold");
        rst_n = 1'b1;
    endtask

    // One clock: advance the model with the inputs sampled at this edge, then compare.
    task automatic step();
        bit fin;
        @(posedge clk); #1;
        fin = 0; m_den = 0; m_to = 0; m_ldrdy = '0;
        if (m_busy) begin
            if (drdy) begin
                fin = 1; m_do = drpdo;
            end else begin
                m_age++;
                if (m_age == TO) begin fin = 1; m_to = 1; m_do = 16'hFFFF; end
            end
            if (fin) begin
                m_busy = 0;
                m_ldrdy[m_own] = 1'b1;
                if (!req[m_own]) m_gnt = '0;
            end
        end else if (m_gnt != 0) begin
            if (den[m_own]) begin
                m_den = 1; m_busy = 1; m_age = 0;
                m_dwe = dwe[m_own]; m_addr = daddr[m_own*16 +: 16]; m_di = di[m_own*16 +: 16];
            end else if (!req[m_own]) begin
                m_gnt = '0;
            end
        end else begin
            for (int i = 1; i <= NL; i++) begin
                int l;
                l = (m_last + i) % NL;
                if (req[l]) begin
                    m_own = l; m_last = l; m_gnt = 4'(1 << l);
                    break;
                end
            end
        end
        chk("gnt", 64'(gnt_o), 64'(m_gnt));
        chk("drp_den", 64'(drp_den_o), 64'(m_den));
        chk("drp_dwe", 64'(drp_dwe_o), 64'(m_dwe));
        chk("drp_daddr", 64'(drp_daddr_o), 64'(m_addr));
        chk("drp_di", 64'(drp_di_o), 64'(m_di));
        chk("lane_drdy", 64'(lane_drdy_o), 64'(m_ldrdy));
        chk("timeout", 64'(timeout_o), 64'(m_to));
        if (m_ldrdy != 0) chk("lane_drpdo", 64'(lane_drpdo_o), 64'(m_do));
    endtask

    initial begin
        clr_inputs();
        rst_n = 1'b1;
        model_reset();
        sl_busy = 0; sl_d = 0; sl_k = 0;
        foreach (started[l]) begin started[l] = 0; inwait[l] = 0; end
        #1 do_reset();

        // single read on lane 0
        req = 4'b0001; step();
        chk("rd_gnt", 64'(gnt_o), 64'h1);
        den[0] = 1'b1; daddr[15:0] = 16'h0042; step();
        chk("rd_den", 64'(drp_den_o), 64'h1);
        chk("rd_addr", 64'(drp_daddr_o), 64'h0042);
        den = '0; step();
        chk("rd_den_1cyc", 64'(drp_den_o), 64'h0);
        step();
        drdy = 1'b1; drpdo = 16'hA5A5; step();
        chk("rd_drdy", 64'(lane_drdy_o), 64'h1);
        chk("rd_data", 64'(lane_drpdo_o), 64'hA5A5);
        drdy = 1'b0; req = '0; step();
        chk("rd_release", 64'(gnt_o), 64'h0);

        // round robin from reset: 0,1,2,3,0 with an idle cycle between grants
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int o;
            o = k % NL;
            step();
            chk("rr_order", 64'(gnt_o), 64'(1 << o));
            den[o] = 1'b1; daddr[o*16 +: 16] = 16'(16'h0100 + k); step();
            den = '0; drdy = 1'b1; drpdo = 16'(k); step();
            chk("rr_drdy", 64'(lane_drdy_o), 64'(1 << o));
            drdy = 1'b0; req[o] = 1'b0; step();
            chk("rr_idle", 64'(gnt_o), 64'h0);
            req[o] = 1'b1;
        end
        req = '0;

        // timeout with no drdy, then a normal transaction on the same grant
        req = 4'b0100; step();
        chk("to_gnt", 64'(gnt_o), 64'h4);
        den[2] = 1'b1; daddr[47:32] = 16'h0777; step();
        den = '0;
        for (int i = 1; i <= TO; i++) begin
            step();
            chk("to_pulse", 64'(timeout_o), 64'(i == TO));
        end
        chk("to_drdy", 64'(lane_drdy_o), 64'h4);
        chk("to_data", 64'(lane_drpdo_o), 64'hFFFF);
        den[2] = 1'b1; daddr[47:32] = 16'h1234; step();
        chk("to_next_den", 64'(drp_den_o), 64'h1);
        den = '0; drdy = 1'b1; drpdo = 16'hBEEF; step();
        chk("to_next_data", 64'(lane_drpdo_o), 64'hBEEF);
        drdy = 1'b0;

        // lane 1 den while lane 2 owns; owner den during WAIT is ignored
        den[1] = 1'b1; daddr[31:16] = 16'hDEAD; step();
        chk("iso_den", 64'(drp_den_o), 64'h0);
        chk("iso_addr", 64'(drp_daddr_o), 64'h1234);
        den = '0; step();
        chk("iso_drdy", 64'(lane_drdy_o[1]), 64'h0);
        den[2] = 1'b1; daddr[47:32] = 16'h0055; step();
        daddr[47:32] = 16'h0066; step();
        chk("wait_den_ign", 64'(drp_den_o), 64'h0);
        den = '0; drdy = 1'b1; drpdo = 16'h1357; step();
        drdy = 1'b0; req = '0; step();

        // drdy on the terminal count is a normal completion
        req = 4'b1000; step();
        den[3] = 1'b1; step();
        den = '0;
        repeat (TO - 1) step();
        drdy = 1'b1; drpdo = 16'h5A5A; step();
        chk("coin_drdy", 64'(lane_drdy_o), 64'h8);
        chk("coin_data", 64'(lane_drpdo_o), 64'h5A5A);
        chk("coin_to", 64'(timeout_o), 64'h0);
        drdy = 1'b0; req = '0; step();

        // reset in the middle of WAIT; late drdy ignored; lane 0 first afterwards
        req = 4'b0010; step();
        den[1] = 1'b1; step();
        den = '0; step(); step();
        do_reset();
        req = '0; drdy = 1'b1; drpdo = 16'h7777; step();
        chk("late_drdy", 64'(lane_drdy_o), 64'h0);
        drdy = 1'b0; req = 4'b1111; step();
        chk("post_rst_gnt", 64'(gnt_o), 64'h1);
        req = '0; step();

        // random lane and DRP-slave traffic
        for (int c = 0; c < 2000; c++) begin
            if (lane_drdy_o != 0) sl_busy = 0;
            if (drp_den_o) begin sl_busy = 1; sl_d = $urandom_range(0, 10); sl_k = 0; end
            drdy = 1'b0; drpdo = 16'($urandom);
            if (sl_busy) begin
                if (sl_k == sl_d) begin drdy = 1'b1; sl_busy = 0; end
                else sl_k++;
            end else if (!drp_den_o && $urandom_range(0, 7) == 0) begin
                drdy = 1'b1;
            end
            den = '0; dwe = 4'($urandom); daddr = {$urandom, $urandom}; di = {$urandom, $urandom};
            for (int l = 0; l < NL; l++) begin
                if (lane_drdy_o[l]) begin
                    started[l] = 0; inwait[l] = 0; req[l] = 1'b0;
                end else if (gnt_o[l]) begin
                    if (drp_den_o) inwait[l] = 1;
                    if (!started[l]) begin
                        int r;
                        r = $urandom_range(0, 7);
                        if (r == 0) req[l] = 1'b0;
                        else if (r < 5) begin den[l] = 1'b1; started[l] = 1; end
                    end else if (inwait[l] && $urandom_range(0, 3) == 0) begin
                        den[l] = 1'b1;
                    end
                end else begin
                    if (!req[l] && $urandom_range(0, 5) == 0) req[l] = 1'b1;
                    if ($urandom_range(0, 7) == 0) den[l] = 1'b1;
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
